// File: rtl/pc_fetch_controller_pkg.sv
// pc_ctrl_pkg: shared types and default widths for the PC fetch controller.
//   pc_state_e : controller state encoding (IDLE/RUN/WAIT/HALT), also the
//                value presented on the top-level state output.
//   pc_sel_e   : next-PC source select driven by the controller into
//                pc_next_calc.
// Optional feature macro: PC_CTRL_LINK_EN (adds the SEL_RET source usage).
package pc_ctrl_pkg;

    localparam int PC_W_DEF  = 4;
    localparam int OFF_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_RET    = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_fetch_controller_if.sv
// pc_fetch_if: fetch handshake between the PC controller and instruction memory.
//   fetch_valid : controller offers pc to imem
//   fetch_ready : imem accepts the offered pc this cycle
//   pc          : current program counter
// Modports: master (controller side), slave (imem side).
interface pc_fetch_if #(
    parameter int PC_W = 4
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [PC_W-1:0] pc;

    modport master (output fetch_valid, output pc, input fetch_ready);
    modport slave  (input fetch_valid, input pc, output fetch_ready);
endinterface

// File: rtl/pc_fetch_controller_next_calc.sv
// pc_next_calc: combinational next-PC selection.
//   pc_i        : current PC
//   sel_i       : next-PC source (pc_sel_e)
//   offset_i    : signed branch offset, sign-extended to PC_W
//   target_i    : absolute jump/call target
//   link_i      : return address (only with PC_CTRL_LINK_EN)
//   next_pc_o   : selected next PC, modulo 2**PC_W
//   wrap_next_o : increment is rolling over from all-ones to zero
module pc_next_calc
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  pc_i,
    input  pc_sel_e          sel_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [PC_W-1:0]  target_i,
`ifdef PC_CTRL_LINK_EN
    input  logic [PC_W-1:0]  link_i,
`endif
    output logic [PC_W-1:0]  next_pc_o,
    output logic             wrap_next_o
);

    logic [PC_W-1:0] off_ext;

    assign off_ext = PC_W'($signed(offset_i));

    always_comb begin
        next_pc_o   = pc_i;
        wrap_next_o = 1'b0;
        case (sel_i)
            SEL_INC: begin
                next_pc_o   = pc_i + PC_W'(1);
                wrap_next_o = &pc_i;
            end
            // Branch overflow is deliberately silent; only +1 reports wrap.
            SEL_BRANCH: next_pc_o = pc_i + off_ext;
            SEL_JUMP:   next_pc_o = target_i;
`ifdef PC_CTRL_LINK_EN
            SEL_RET:    next_pc_o = link_i;
`endif
            default:    next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: program counter sequencer for the fetch stage.
//   clk, reset_n       : clock, async active-low reset
//   start              : leave IDLE
//   stall              : pause fetch (RUN -> WAIT)
//   halt_req           : stop until reset
//   jump/jump_target   : absolute next PC on handshake
//   branch_taken/_offset: relative next PC on handshake
//   fetch (master)     : fetch_valid/fetch_ready/pc handshake to imem
//   wrap               : one-cycle pulse when +1 rolls all-ones -> 0
//   halted, state      : status
// Optional macro PC_CTRL_LINK_EN adds call/ret inputs and the link output.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | pc offered to imem, advances on handshake
// WAIT  | stalled, fetch_valid low, pc held
// HALT  | stopped, only reset_n leaves
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              OFF_W    = OFF_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
`ifdef PC_CTRL_LINK_EN
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  link,
`endif
    pc_fetch_if.master       fetch,
    output logic             wrap,
    output logic             halted,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_HALT = HALT;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            wrap_q, wrap_d;
    logic            hs;
    logic            take;
    pc_sel_e         sel;

    assign hs   = (state_q == S_RUN) && fetch.fetch_ready;
    // A halt request in the handshake cycle suppresses the PC update.
    assign take = hs && !halt_req;

`ifdef PC_CTRL_LINK_EN
    logic [PC_W-1:0] link_q, link_d;

    assign link_d = (take && !ret && call) ? (pc_q + PC_W'(1)) : link_q;
    assign link   = link_q;
`endif

    always_comb begin
        sel = SEL_HOLD;
        if (take) begin
`ifdef PC_CTRL_LINK_EN
            if (ret)               sel = SEL_RET;
            else if (call)         sel = SEL_JUMP;
            else
`endif
            if (jump)              sel = SEL_JUMP;
            else if (branch_taken) sel = SEL_BRANCH;
            else                   sel = SEL_INC;
        end
    end

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_calc (
        .pc_i        (pc_q),
        .sel_i       (sel),
        .offset_i    (branch_offset),
        .target_i    (jump_target),
`ifdef PC_CTRL_LINK_EN
        .link_i      (link_q),
`endif
        .next_pc_o   (pc_d),
        .wrap_next_o (wrap_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (halt_req)   state_d = S_HALT;
                else if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_req)   state_d = S_HALT;
                else if (stall) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (halt_req)    state_d = S_HALT;
                else if (!stall) state_d = S_RUN;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef PC_CTRL_LINK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) link_q <= '0;
        else          link_q <= link_d;
    end
`endif

    assign fetch.fetch_valid = (state_q == S_RUN);
    assign fetch.pc          = pc_q;
    assign wrap              = wrap_q;
    assign halted            = (state_q == S_HALT);
    assign state             = state_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
module tb_pc_fetch_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stall, halt_req, jump, branch_taken;
    logic [3:0] jump_target, branch_offset;
    logic       wrap, halted;
    logic [1:0] state;
`ifdef PC_CTRL_LINK_EN
    logic       call, ret;
    logic [3:0] link;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: state as 0..3, pc as plain integer modulo 16.
    int m_state, m_pc, m_link;
    bit m_wrap;

    pc_fetch_if #(.PC_W(4)) fif ();

    pc_fetch_controller #(.PC_W(4), .OFF_W(4), .RESET_PC(4'd0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .halt_req      (halt_req),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
`ifdef PC_CTRL_LINK_EN
        .call          (call),
        .ret           (ret),
        .link          (link),
`endif
        .fetch         (fif),
        .wrap          (wrap),
        .halted        (halted),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", {30'd0, state}, m_state);
        chk("pc", {28'd0, fif.pc}, m_pc);
        chk("fetch_valid", {31'd0, fif.fetch_valid}, (m_state == 1) ? 1 : 0);
        chk("wrap", {31'd0, wrap}, m_wrap);
        chk("halted", {31'd0, halted}, (m_state == 3) ? 1 : 0);
`ifdef PC_CTRL_LINK_EN
        chk("link", {28'd0, link}, m_link);
`endif
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_link  = 0;
        m_wrap  = 0;
    endtask

    task automatic model_step();
        bit hs;
        int off, nstate, npc;
        bit nwrap;
        hs     = (m_state == 1) && fif.fetch_ready;
        off    = int'(branch_offset);
        if (off >= 8) off -= 16;
        nstate = m_state;
        npc    = m_pc;
        nwrap  = 0;
        case (m_state)
            0: if (halt_req) nstate = 3; else if (start) nstate = 1;
            1: begin
                if (halt_req) nstate = 3;
                else begin
                    if (hs) begin
`ifdef PC_CTRL_LINK_EN
                        if (ret) npc = m_link;
                        else if (call) begin
                            npc    = int'(jump_target);
                            m_link = (m_pc + 1) % 16;
                        end else
`endif
                        if (jump) npc = int'(jump_target);
                        else if (branch_taken) npc = ((m_pc + off) % 16 + 16) % 16;
                        else begin
                            npc   = (m_pc + 1) % 16;
                            nwrap = (m_pc == 15);
                        end
                    end
                    if (stall) nstate = 2;
                end
            end
            2: if (halt_req) nstate = 3; else if (!stall) nstate = 1;
            default: nstate = 3;
        endcase
        m_state = nstate;
        m_pc    = npc;
        m_wrap  = nwrap;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #2;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        check_all();
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt_req = 0; jump = 0; branch_taken = 0;
        jump_target = 4'd0; branch_offset = 4'd0;
`ifdef PC_CTRL_LINK_EN
        call = 0; ret = 0;
`endif
    endtask

    initial begin
        clear_inputs();
        fif.fetch_ready = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        check_all();

        // Free run with wrap.
        start = 1; fif.fetch_ready = 1'b1;
        cycle();
        start = 0;
        chk("run_first_pc", {28'd0, fif.pc}, 0);
        for (int i = 0; i < 15; i++) cycle();
        chk("run_pc15", {28'd0, fif.pc}, 15);
        cycle();
        chk("wrap_pulse", {31'd0, wrap}, 1);
        chk("wrap_pc0", {28'd0, fif.pc}, 0);
        cycle();
        chk("wrap_clear", {31'd0, wrap}, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("at_pc5", {28'd0, fif.pc}, 5);

        // Backpressure.
        fif.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_pc", {28'd0, fif.pc}, 5);
            chk("bp_valid", {31'd0, fif.fetch_valid}, 1);
        end
        fif.fetch_ready = 1'b1;
        cycle();
        chk("bp_release_pc", {28'd0, fif.pc}, 6);

        // Branch and jump.
        branch_taken = 1; branch_offset = 4'hD;
        cycle();
        chk("branch_back_pc", {28'd0, fif.pc}, 3);
        jump = 1; jump_target = 4'd12;
        cycle();
        chk("jump_over_branch", {28'd0, fif.pc}, 12);
        jump = 0; branch_taken = 0;
        cycle();
        cycle();
        branch_taken = 1; branch_offset = 4'd4;
        cycle();
        chk("branch_wrap_pc", {28'd0, fif.pc}, 2);
        chk("branch_wrap_silent", {31'd0, wrap}, 0);
        branch_taken = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("at_pc7", {28'd0, fif.pc}, 7);

        // Stall.
        stall = 1;
        cycle();
        chk("stall_state", {30'd0, state}, 2);
        chk("stall_pc", {28'd0, fif.pc}, 8);
        cycle();
        chk("stall_hold_valid", {31'd0, fif.fetch_valid}, 0);
        stall = 0;
        cycle();
        chk("unstall_state", {30'd0, state}, 1);
        cycle();
        chk("unstall_pc", {28'd0, fif.pc}, 9);

        // Halt with jump in the same cycle.
        halt_req = 1; jump = 1; jump_target = 4'd3;
        cycle();
        chk("halt_pc", {28'd0, fif.pc}, 9);
        chk("halt_flag", {31'd0, halted}, 1);
        halt_req = 0; jump = 0; start = 1;
        cycle();
        cycle();
        chk("halt_sticky", {30'd0, state}, 3);
        start = 0;
        do_reset();
        chk("reset_from_halt", {30'd0, state}, 0);

`ifdef PC_CTRL_LINK_EN
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 4; i++) cycle();
        call = 1; jump_target = 4'd10;
        cycle();
        chk("call_pc", {28'd0, fif.pc}, 10);
        chk("call_link", {28'd0, link}, 5);
        call = 0; ret = 1;
        cycle();
        chk("ret_pc", {28'd0, fif.pc}, 5);
        ret = 0;
        do_reset();
`endif

        // Start and halt together in IDLE.
        start = 1; halt_req = 1;
        cycle();
        chk("idle_halt", {30'd0, state}, 3);
        clear_inputs();
        do_reset();

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            start         = ($urandom_range(0, 2) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            halt_req      = ($urandom_range(0, 49) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 2) == 0);
            jump_target   = 4'($urandom);
            branch_offset = 4'($urandom);
`ifdef PC_CTRL_LINK_EN
            call          = ($urandom_range(0, 7) == 0);
            ret           = ($urandom_range(0, 7) == 0);
`endif
            fif.fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0 || (m_state == 3 && $urandom_range(0, 4) == 0))
                do_reset();
            else
                cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
